regfile_bypass: RTL and testbench
=================================

REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 SHALL have parameter DW, default 32, data width.
REQ-002 SHALL have parameter AW, default 5, register address width; depth 2**AW.
REQ-003 SHALL have parameter NRP, default 2, read-port count (1..4).
REQ-004 SHALL have parameter LINK_REG, default 26, exception/interrupt link register.
REQ-005 SHALL have parameters UA_REG=4, UB_REG=5, RES_REG=2: UART operand A, operand B and result registers.
REQ-006 SHALL have ports clk (in, 1, clock) and rst_n (in, 1, reset): one clock; reset is synchronous and active-low.
REQ-007 SHALL have ports wb_we (in, 1), wb_addr (in, AW) and wb_data (in, DW): writeback write.
REQ-008 SHALL have ports exc_we (in, 1, undefined-instruction link write) and exc_data (in, DW).
REQ-009 SHALL have ports irq_we (in, 1, interrupt link write) and irq_data (in, DW).
REQ-010 SHALL have ports rd_addr (in, NRP*AW) and rd_data (out, NRP*DW): packed read ports, port i at slice i.
REQ-011 SHALL have ports uart_signal (in, 1, byte strobe), uart_flag (in, 1; 0 = A, 1 = B) and uart_rx_data (in, 8).
REQ-012 SHALL have ports uart_result_data (out, 8), result_valid (out, 1) and uart_overflow (out, 1, sticky).

Function
REQ-013 Register 0 SHALL read as 0 and SHALL ignore all writes.
REQ-014 Reads SHALL be combinational; rd_data[i] SHALL equal the value that will be committed to rd_addr[i] at the next edge if a write to it is active this cycle (bypass), otherwise the stored value.
REQ-015 Write priority on a same-address collision SHALL be exc > irq > wb > uart; non-colliding writes SHALL all commit in the same cycle.
REQ-016 exc_we and irq_we SHALL write LINK_REG; if both are asserted, exc_data SHALL be written.
REQ-017 A UART strobe SHALL produce the write {old[DW-9:0], uart_rx_data} to UA_REG (flag 0) or UB_REG (flag 1), where old is the bypassed current value of that register.
REQ-018 A UART write that collides with a higher-priority write to the same register SHALL be held in a one-entry pending buffer and retried each cycle until it commits.
REQ-019 A pending entry SHALL commit before a newly arriving strobe; the new strobe in that cycle SHALL go into the buffer.
REQ-020 A strobe arriving while the buffer is full and cannot drain SHALL be dropped and SHALL set uart_overflow, which stays set until reset.
REQ-021 uart_result_data SHALL be the registered low byte of RES_REG, updated one cycle after any write to RES_REG.
REQ-022 result_valid SHALL pulse high for exactly one cycle, aligned with the uart_result_data update, after each wb write to RES_REG.
REQ-023 Pending-buffer states SHALL be EMPTY and HELD: EMPTY to HELD on a blocked UART write; HELD to EMPTY on commit with no new blocked strobe.
REQ-024 All writes SHALL take effect at the rising clk edge, with latency 1 to a non-bypassed read.

Reset
REQ-025 With rst_n low at an edge, all registers, uart_result_data, result_valid, uart_overflow and the pending buffer SHALL clear to 0/EMPTY.
REQ-026 Reset SHALL override any write active in the same cycle, and a pending UART byte SHALL be discarded.
REQ-027 rd_data SHALL show bypass values even while rst_n is low; the committed state SHALL be 0 after the edge.

Structure
REQ-028 The default widths, the LINK_REG/UA_REG/UB_REG/RES_REG defaults and the pending-state encoding SHALL live in the shared CPU package.
REQ-029 The block SHALL contain one sub-module, regfile_wprio, which resolves per-address write priority and bypass data.

Verification
REQ-030 Write 0xDEADBEEF to r0 via wb -> all ports read 0 at r0.
REQ-031 wb_we to r7 = 0x1234 and rd_addr[0]=7 in the same cycle -> rd_data[0]=0x1234 that cycle and every later cycle.
REQ-032 exc_we=1, exc_data=0x400, irq_we=1, irq_data=0x800, and wb to r26 = 0x1, all together -> r26=0x400.
REQ-033 UART strobes 0x12 then 0x34 with flag 0 -> r4=0x00001234.
REQ-034 UART strobe to r4 while wb writes r4 for 3 cycles, plus a second strobe in cycle 2 -> second strobe dropped, uart_overflow=1, r4 gets wb value, then the first byte appended.
REQ-035 wb writes r2=0x1A5 -> next cycle uart_result_data=0xA5 and result_valid=1 for one cycle; rst_n low mid-sequence -> all outputs 0.

Source files
------------

// File: rtl/regfile_bypass_pkg.sv
// Shared CPU definitions for the bypassing register file.
// Holds the default widths, the special register indices and the pending-buffer state encoding.
package regfile_bypass_pkg;

  localparam int unsigned DW_DEF       = 32;
  localparam int unsigned AW_DEF       = 5;
  localparam int unsigned LINK_REG_DEF = 26;
  localparam int unsigned UA_REG_DEF   = 4;
  localparam int unsigned UB_REG_DEF   = 5;
  localparam int unsigned RES_REG_DEF  = 2;

  typedef enum logic {
    PendEmpty = 1'b0,
    PendHeld  = 1'b1
  } pend_state_e;

endpackage

// File: rtl/regfile_wprio.sv
// Per-address write arbitration: exc > irq > wb > uart.
// Produces the committed data for every register and whether the UART write lost.
module regfile_wprio
  import regfile_bypass_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned LINK_REG = LINK_REG_DEF
) (
  input  logic                   wb_we,
  input  logic [AW-1:0]          wb_addr,
  input  logic [DW-1:0]          wb_data,
  input  logic                   exc_we,
  input  logic [DW-1:0]          exc_data,
  input  logic                   irq_we,
  input  logic [DW-1:0]          irq_data,
  input  logic                   uart_we,
  input  logic [AW-1:0]          uart_addr,
  input  logic [DW-1:0]          uart_data,
  output logic [(1<<AW)-1:0]     wr_en,
  output logic [DW-1:0]          wr_data [1<<AW],
  output logic                   uart_blocked
);

  localparam int unsigned Depth = 1 << AW;
  localparam logic [AW-1:0] LinkAddr = AW'(LINK_REG);

  always_comb begin
    uart_blocked = uart_we &&
                   (((exc_we || irq_we) && (uart_addr == LinkAddr)) ||
                    (wb_we && (wb_addr == uart_addr)));
    wr_en = '0;
    for (int i = 0; i < Depth; i++) begin
      wr_data[i] = '0;
    end
    // Lowest priority first so that higher-priority sources overwrite on collision.
    if (uart_we && !uart_blocked) begin
      wr_en[uart_addr]   = 1'b1;
      wr_data[uart_addr] = uart_data;
    end
    if (wb_we) begin
      wr_en[wb_addr]   = 1'b1;
      wr_data[wb_addr] = wb_data;
    end
    if (irq_we) begin
      wr_en[LinkAddr]   = 1'b1;
      wr_data[LinkAddr] = irq_data;
    end
    if (exc_we) begin
      wr_en[LinkAddr]   = 1'b1;
      wr_data[LinkAddr] = exc_data;
    end
    // r0 is hardwired to zero.
    wr_en[0]   = 1'b0;
    wr_data[0] = '0;
  end

endmodule

// File: rtl/regfile_bypass.sv
// Multi-port register file with write bypass, link-register writes and a UART byte shifter
// that retries collided bytes from a one-entry pending buffer.
module regfile_bypass
  import regfile_bypass_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned NRP      = 2,
  parameter int unsigned LINK_REG = LINK_REG_DEF,
  parameter int unsigned UA_REG   = UA_REG_DEF,
  parameter int unsigned UB_REG   = UB_REG_DEF,
  parameter int unsigned RES_REG  = RES_REG_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DW-1:0]     wb_data,
  input  logic              exc_we,
  input  logic [DW-1:0]     exc_data,
  input  logic              irq_we,
  input  logic [DW-1:0]     irq_data,
  input  logic [NRP*AW-1:0] rd_addr,
  output logic [NRP*DW-1:0] rd_data,
  input  logic              uart_signal,
  input  logic              uart_flag,
  input  logic [7:0]        uart_rx_data,
  output logic [7:0]        uart_result_data,
  output logic              result_valid,
  output logic              uart_overflow
);

  localparam int unsigned Depth = 1 << AW;
  localparam logic [AW-1:0] UaAddr  = AW'(UA_REG);
  localparam logic [AW-1:0] UbAddr  = AW'(UB_REG);
  localparam logic [AW-1:0] ResAddr = AW'(RES_REG);

  logic [DW-1:0]    regs_q  [Depth];
  logic [DW-1:0]    regs_d  [Depth];
  logic [DW-1:0]    wr_data [Depth];
  logic [Depth-1:0] wr_en;

  pend_state_e pend_q, pend_d;
  logic        pend_flag_q, pend_flag_d;
  logic [7:0]  pend_byte_q, pend_byte_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  res_data_q;
  logic        res_valid_q;

  logic          uart_req;
  logic          uart_sel;
  logic [7:0]    uart_byte;
  logic [AW-1:0] uart_addr;
  logic [DW-1:0] uart_data;
  logic          uart_blocked;

  // A held byte always takes the UART write slot ahead of a fresh strobe.
  always_comb begin
    uart_req  = uart_signal;
    uart_sel  = uart_flag;
    uart_byte = uart_rx_data;
    if (pend_q == PendHeld) begin
      uart_req  = 1'b1;
      uart_sel  = pend_flag_q;
      uart_byte = pend_byte_q;
    end
  end

  assign uart_addr = uart_sel ? UbAddr : UaAddr;
  assign uart_data = {regs_q[uart_addr][DW-9:0], uart_byte};

  regfile_wprio #(
    .DW       (DW),
    .AW       (AW),
    .LINK_REG (LINK_REG)
  ) u_wprio (
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .exc_we       (exc_we),
    .exc_data     (exc_data),
    .irq_we       (irq_we),
    .irq_data     (irq_data),
    .uart_we      (uart_req),
    .uart_addr    (uart_addr),
    .uart_data    (uart_data),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .uart_blocked (uart_blocked)
  );

  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      regs_d[i] = wr_en[i] ? wr_data[i] : regs_q[i];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NRP; p++) begin
      rd_data[p*DW +: DW] = regs_d[rd_addr[p*AW +: AW]];
    end
  end

  always_comb begin
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    pend_byte_d = pend_byte_q;
    overflow_d  = overflow_q;
    case (pend_q)
      PendEmpty: begin
        if (uart_signal && uart_blocked) begin
          pend_d      = PendHeld;
          pend_flag_d = uart_flag;
          pend_byte_d = uart_rx_data;
        end
      end
      PendHeld: begin
        if (!uart_blocked) begin
          if (uart_signal) begin
            pend_flag_d = uart_flag;
            pend_byte_d = uart_rx_data;
          end else begin
            pend_d = PendEmpty;
          end
        end else if (uart_signal) begin
          overflow_d = 1'b1;
        end
      end
      default: pend_d = PendEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
      pend_q      <= PendEmpty;
      pend_flag_q <= 1'b0;
      pend_byte_q <= '0;
      overflow_q  <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
      pend_byte_q <= pend_byte_d;
      overflow_q  <= overflow_d;
      res_data_q  <= regs_d[ResAddr][7:0];
      res_valid_q <= wb_we && (wb_addr == ResAddr) && (ResAddr != '0);
    end
  end

  assign uart_result_data = res_data_q;
  assign result_valid     = res_valid_q;
  assign uart_overflow    = overflow_q;

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed self-checking bench for regfile_bypass with default parameters.
module tb_regfile_bypass;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        exc_we;
  logic [31:0] exc_data;
  logic        irq_we;
  logic [31:0] irq_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        uart_signal;
  logic        uart_flag;
  logic [7:0]  uart_rx_data;
  logic [7:0]  uart_result_data;
  logic        result_valid;
  logic        uart_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_bypass dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wb_we            (wb_we),
    .wb_addr          (wb_addr),
    .wb_data          (wb_data),
    .exc_we           (exc_we),
    .exc_data         (exc_data),
    .irq_we           (irq_we),
    .irq_data         (irq_data),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .uart_signal      (uart_signal),
    .uart_flag        (uart_flag),
    .uart_rx_data     (uart_rx_data),
    .uart_result_data (uart_result_data),
    .result_valid     (result_valid),
    .uart_overflow    (uart_overflow)
  );

  task automatic idle();
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    exc_we = 1'b0; exc_data = '0;
    irq_we = 1'b0; irq_data = '0;
    uart_signal = 1'b0; uart_flag = 1'b0; uart_rx_data = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    rd_addr = '0;
    tick();
    tick();
    rst_n = 1'b1;
    set_rd(5'd4, 5'd26);
    checks++;
    if (uart_result_data !== 8'h00) begin
      errors++; $display("FAIL reset_result_data: got %h expected 00", uart_result_data);
    end
    checks++;
    if (result_valid !== 1'b0) begin
      errors++; $display("FAIL reset_result_valid: got %b expected 0", result_valid);
    end
    checks++;
    if (uart_overflow !== 1'b0) begin
      errors++; $display("FAIL reset_overflow: got %b expected 0", uart_overflow);
    end
    checks++;
    if (rd_data !== 64'h0) begin
      errors++; $display("FAIL reset_regs: got %h expected 0", rd_data);
    end
  endtask

  task automatic test_r0();
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEADBEEF;
    set_rd(5'd0, 5'd0);
    checks++;
    if (rd_data !== 64'h0) begin
      errors++; $display("FAIL r0_bypass: got %h expected 0", rd_data);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data !== 64'h0) begin
      errors++; $display("FAIL r0_stored: got %h expected 0", rd_data);
    end
  endtask

  task automatic test_bypass();
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
    set_rd(5'd7, 5'd0);
    checks++;
    if (rd_data[31:0] !== 32'h1234) begin
      errors++; $display("FAIL bypass_same_cycle: got %h expected 00001234", rd_data[31:0]);
    end
    tick();
    idle();
    set_rd(5'd7, 5'd7);
    checks++;
    if (rd_data !== {32'h1234, 32'h1234}) begin
      errors++; $display("FAIL bypass_stored: got %h expected both 00001234", rd_data);
    end
    tick();
    checks++;
    if (rd_data[31:0] !== 32'h1234) begin
      errors++; $display("FAIL bypass_hold: got %h expected 00001234", rd_data[31:0]);
    end
  endtask

  task automatic test_priority();
    exc_we = 1'b1; exc_data = 32'h400;
    irq_we = 1'b1; irq_data = 32'h800;
    wb_we = 1'b1; wb_addr = 5'd26; wb_data = 32'h1;
    set_rd(5'd26, 5'd0);
    checks++;
    if (rd_data[31:0] !== 32'h400) begin
      errors++; $display("FAIL prio_exc_bypass: got %h expected 00000400", rd_data[31:0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h400) begin
      errors++; $display("FAIL prio_exc_stored: got %h expected 00000400", rd_data[31:0]);
    end
    irq_we = 1'b1; irq_data = 32'h800;
    wb_we = 1'b1; wb_addr = 5'd26; wb_data = 32'h5;
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h800) begin
      errors++; $display("FAIL prio_irq_over_wb: got %h expected 00000800", rd_data[31:0]);
    end
    // Non-colliding exc, wb and uart writes all land together.
    exc_we = 1'b1; exc_data = 32'h10;
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
    uart_signal = 1'b1; uart_flag = 1'b1; uart_rx_data = 8'h55;
    tick();
    idle();
    set_rd(5'd26, 5'd9);
    checks++;
    if (rd_data !== {32'h99, 32'h10}) begin
      errors++; $display("FAIL parallel_exc_wb: got %h expected 00000099_00000010", rd_data);
    end
    set_rd(5'd5, 5'd0);
    checks++;
    if (rd_data[31:0] !== 32'h55) begin
      errors++; $display("FAIL parallel_uart: got %h expected 00000055", rd_data[31:0]);
    end
  endtask

  task automatic test_uart_append();
    uart_signal = 1'b1; uart_flag = 1'b0; uart_rx_data = 8'h12;
    tick();
    uart_rx_data = 8'h34;
    set_rd(5'd4, 5'd0);
    checks++;
    if (rd_data[31:0] !== 32'h1234) begin
      errors++; $display("FAIL uart_bypass: got %h expected 00001234", rd_data[31:0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h1234) begin
      errors++; $display("FAIL uart_append: got %h expected 00001234", rd_data[31:0]);
    end
  endtask

  task automatic test_uart_pending_order();
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h11223344;
    uart_signal = 1'b1; uart_flag = 1'b1; uart_rx_data = 8'h01;
    tick();
    idle();
    uart_signal = 1'b1; uart_flag = 1'b1; uart_rx_data = 8'h02;
    set_rd(5'd5, 5'd0);
    checks++;
    if (rd_data[31:0] !== 32'h22334401) begin
      errors++; $display("FAIL pend_first_commit: got %h expected 22334401", rd_data[31:0]);
    end
    tick();
    idle();
    tick();
    checks++;
    if (rd_data[31:0] !== 32'h33440102) begin
      errors++; $display("FAIL pend_second_commit: got %h expected 33440102", rd_data[31:0]);
    end
    checks++;
    if (uart_overflow !== 1'b0) begin
      errors++; $display("FAIL pend_no_overflow: got %b expected 0", uart_overflow);
    end
  endtask

  task automatic test_uart_collision();
    wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'hAABBCCDD;
    uart_signal = 1'b1; uart_flag = 1'b0; uart_rx_data = 8'h77;
    set_rd(5'd4, 5'd0);
    checks++;
    if (rd_data[31:0] !== 32'hAABBCCDD) begin
      errors++; $display("FAIL coll_wb_wins: got %h expected AABBCCDD", rd_data[31:0]);
    end
    tick();
    uart_rx_data = 8'h88;
    tick();
    uart_signal = 1'b0;
    checks++;
    if (uart_overflow !== 1'b1) begin
      errors++; $display("FAIL coll_overflow: got %b expected 1", uart_overflow);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[31:0] !== 32'hBBCCDD77) begin
      errors++; $display("FAIL coll_retry_bypass: got %h expected BBCCDD77", rd_data[31:0]);
    end
    tick();
    tick();
    checks++;
    if (rd_data[31:0] !== 32'hBBCCDD77) begin
      errors++; $display("FAIL coll_retry_stored: got %h expected BBCCDD77", rd_data[31:0]);
    end
    checks++;
    if (uart_overflow !== 1'b1) begin
      errors++; $display("FAIL coll_overflow_sticky: got %b expected 1", uart_overflow);
    end
  endtask

  task automatic test_result();
    wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h1A5;
    tick();
    idle();
    checks++;
    if (uart_result_data !== 8'hA5) begin
      errors++; $display("FAIL result_data: got %h expected A5", uart_result_data);
    end
    checks++;
    if (result_valid !== 1'b1) begin
      errors++; $display("FAIL result_valid_pulse: got %b expected 1", result_valid);
    end
    tick();
    checks++;
    if (result_valid !== 1'b0) begin
      errors++; $display("FAIL result_valid_drop: got %b expected 0", result_valid);
    end
    checks++;
    if (uart_result_data !== 8'hA5) begin
      errors++; $display("FAIL result_data_hold: got %h expected A5", uart_result_data);
    end
  endtask

  task automatic test_reset_mid();
    wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h1C3;
    tick();
    rst_n = 1'b0;
    wb_data = 32'h77;
    set_rd(5'd2, 5'd0);
    checks++;
    if (rd_data[31:0] !== 32'h77) begin
      errors++; $display("FAIL reset_bypass: got %h expected 00000077", rd_data[31:0]);
    end
    tick();
    idle();
    rst_n = 1'b1;
    set_rd(5'd2, 5'd4);
    checks++;
    if ({uart_result_data, result_valid, uart_overflow} !== 10'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got data=%h valid=%b ovf=%b expected 0",
               uart_result_data, result_valid, uart_overflow);
    end
    checks++;
    if (rd_data !== 64'h0) begin
      errors++; $display("FAIL reset_mid_regs: got %h expected 0", rd_data);
    end
    set_rd(5'd26, 5'd5);
    checks++;
    if (rd_data !== 64'h0) begin
      errors++; $display("FAIL reset_mid_link: got %h expected 0", rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_r0();
    test_bypass();
    test_priority();
    test_uart_append();
    test_uart_pending_order();
    test_uart_collision();
    test_result();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
